// File: rtl/barrel_unrotator_if.sv
// Stream bundle for barrel_unrotator: input beat, output beat and flush.
interface barrel_unrotator_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int SA_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [SA_WIDTH-1:0]   shift_amount;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic [SA_WIDTH-1:0]   sa_out;

    modport slave (
        input  flush, in_valid, shift_amount, data_in, out_ready,
        output in_ready, out_valid, data_out, sa_out
    );

    modport master (
        output flush, in_valid, shift_amount, data_in, out_ready,
        input  in_ready, out_valid, data_out, sa_out
    );
endinterface

// File: rtl/barrel_unrotator.sv
// Pipelined right-rotator with valid/ready flow control and per-stage stall propagation.
// Optional BARREL_UNROT_SKID_EN adds a registered-ready 1-entry input skid buffer.
module barrel_unrotator #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    barrel_unrotator_if.slave bus
);
    localparam int SA_WIDTH       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int EFF_NUM_STAGES = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
    localparam int OPS_BASE       = SA_WIDTH / EFF_NUM_STAGES;
    localparam int OPS_REM        = SA_WIDTH % EFF_NUM_STAGES;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [SA_WIDTH-1:0]   sa_t;

    // First rotate op owned by stage s; op_lo(s+1) bounds it. Early stages get the remainder ops.
    function automatic int op_lo(input int s);
        return s * OPS_BASE + ((s < OPS_REM) ? s : OPS_REM);
    endfunction

    function automatic word_t ror_pow2(input word_t w, input int k);
        int unsigned amt;
        amt = (32'd1 << k) % DATA_WIDTH;
        return (w >> amt) | (w << (DATA_WIDTH - amt));
    endfunction

    logic [EFF_NUM_STAGES-1:0]  vld_q, vld_d;
    word_t [EFF_NUM_STAGES-1:0] data_q, data_d;
    sa_t [EFF_NUM_STAGES-1:0]   sa_q, sa_d;
    logic [EFF_NUM_STAGES:0]    load;
    logic [EFF_NUM_STAGES-1:0]  stg_vld;
    word_t [EFF_NUM_STAGES-1:0] stg_data, stg_rot;
    sa_t [EFF_NUM_STAGES-1:0]   stg_sa;
    logic                       rdy_q;
    logic                       in_ready, accept, src_vld;
    word_t                      src_data;
    sa_t                        src_sa;

    always_comb begin
        load = '0;
        load[EFF_NUM_STAGES] = bus.out_ready;
        for (int s = EFF_NUM_STAGES - 1; s >= 0; s--)
            load[s] = !vld_q[s] || load[s+1];
    end

`ifdef BARREL_UNROT_SKID_EN
    logic  skid_vld_q, skid_vld_d;
    word_t skid_data_q;
    sa_t   skid_sa_q;

    assign in_ready = rdy_q && !skid_vld_q && !bus.flush;
    assign accept   = bus.in_valid && in_ready;
    assign src_vld  = skid_vld_q || accept;
    assign src_data = skid_vld_q ? skid_data_q : bus.data_in;
    assign src_sa   = skid_vld_q ? skid_sa_q : bus.shift_amount;

    always_comb begin
        skid_vld_d = skid_vld_q;
        if (skid_vld_q && load[0])
            skid_vld_d = 1'b0;
        else if (accept && !load[0])
            skid_vld_d = 1'b1;
        if (bus.flush)
            skid_vld_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sa_q   <= '0;
        end else begin
            skid_vld_q <= skid_vld_d;
            if (accept && !load[0]) begin
                skid_data_q <= bus.data_in;
                skid_sa_q   <= bus.shift_amount;
            end
        end
    end
`else
    // Ready ripples combinationally from out_ready through every stage.
    assign in_ready = rdy_q && load[0] && !bus.flush;
    assign accept   = bus.in_valid && in_ready;
    assign src_vld  = accept;
    assign src_data = bus.data_in;
    assign src_sa   = bus.shift_amount;
`endif

    always_comb begin
        stg_vld  = '0;
        stg_data = '0;
        stg_sa   = '0;
        stg_rot  = '0;
        vld_d    = vld_q;
        data_d   = data_q;
        sa_d     = sa_q;
        for (int s = 0; s < EFF_NUM_STAGES; s++) begin
            stg_vld[s]  = (s == 0) ? src_vld  : vld_q[(s > 0) ? s - 1 : 0];
            stg_data[s] = (s == 0) ? src_data : data_q[(s > 0) ? s - 1 : 0];
            stg_sa[s]   = (s == 0) ? src_sa   : sa_q[(s > 0) ? s - 1 : 0];
            stg_rot[s]  = stg_data[s];
            for (int k = 0; k < SA_WIDTH; k++)
                if (k >= op_lo(s) && k < op_lo(s + 1) && stg_sa[s][k])
                    stg_rot[s] = ror_pow2(stg_rot[s], k);
            // Data only moves with a real beat so bubbles leave the registers untouched.
            if (load[s]) begin
                vld_d[s] = stg_vld[s];
                if (stg_vld[s]) begin
                    data_d[s] = stg_rot[s];
                    sa_d[s]   = stg_sa[s];
                end
            end
            if (bus.flush)
                vld_d[s] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            data_q <= '0;
            sa_q   <= '0;
            rdy_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            sa_q   <= sa_d;
            rdy_q  <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_q[EFF_NUM_STAGES-1];
    assign bus.data_out  = data_q[EFF_NUM_STAGES-1];
    assign bus.sa_out    = sa_q[EFF_NUM_STAGES-1];
endmodule

// File: tb/tb_barrel_unrotator.sv
// Directed bench for barrel_unrotator: 32-bit/2-stage instance plus a 1-bit/0-stage instance.
module tb_barrel_unrotator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    barrel_unrotator_if #(.DATA_WIDTH(32)) b32 ();
    barrel_unrotator_if #(.DATA_WIDTH(1))  b1 ();

    barrel_unrotator #(.DATA_WIDTH(32), .NUM_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(b32));
    barrel_unrotator #(.DATA_WIDTH(1),  .NUM_STAGES(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BARREL_UNROT_SKID_EN
    localparam int STALL_CAP = 3;
`else
    localparam int STALL_CAP = 2;
`endif

    function automatic logic [31:0] rol32(input logic [31:0] w, input logic [4:0] s);
        return (w << s) | (w >> (6'd32 - {1'b0, s}));
    endfunction

    task automatic test_reset();
        b32.flush = 0; b32.in_valid = 0; b32.shift_amount = '0; b32.data_in = '0; b32.out_ready = 0;
        b1.flush = 0;  b1.in_valid = 0;  b1.shift_amount = '0;  b1.data_in = '0;  b1.out_ready = 0;
        reset = 0;
        #1 reset = 1;
        #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", b32.out_valid); end
        n_cmp++; if (b32.data_out !== 32'h0) begin n_bad++; $display("FAIL rst_data_out: got %h expected 0", b32.data_out); end
        n_cmp++; if (b32.sa_out !== 5'h0) begin n_bad++; $display("FAIL rst_sa_out: got %h expected 0", b32.sa_out); end
        n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_low: got %b expected 0", b32.in_ready); end
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_n_out_valid: got %b expected 0", b1.out_valid); end
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk); #1;
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_high: got %b expected 1", b32.in_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        b32.out_ready = 1; b32.data_in = 32'h8000_0001; b32.shift_amount = 5'd1; b32.in_valid = 1;
        #1;
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL t1_accept: got %b expected 1", b32.in_ready); end
        @(negedge clk); b32.in_valid = 0; #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_early: got %b expected 0", b32.out_valid); end
        @(negedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid: got %b expected 1", b32.out_valid); end
        n_cmp++; if (b32.data_out !== 32'hC000_0000) begin n_bad++; $display("FAIL t1_data: got %h expected c0000000", b32.data_out); end
        n_cmp++; if (b32.sa_out !== 5'd1) begin n_bad++; $display("FAIL t1_sa: got %h expected 1", b32.sa_out); end
        @(negedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_no_dup: got %b expected 0", b32.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  sas [4];
        logic [31:0] exp [4];
        sas = '{5'd0, 5'd4, 5'd31, 5'd16};
        exp = '{32'h1234_5678, 32'h8123_4567, 32'h2468_ACF0, 32'h5678_1234};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b32.out_ready = 1;
            if (i < 4) begin
                b32.in_valid = 1; b32.data_in = 32'h1234_5678; b32.shift_amount = sas[i];
            end else b32.in_valid = 0;
            #1;
            if (i < 4) begin
                n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL t2_ready[%0d]: got %b expected 1", i, b32.in_ready); end
            end
            if (i >= 2) begin
                n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL t2_valid[%0d]: got %b expected 1", i - 2, b32.out_valid); end
                n_cmp++; if (b32.data_out !== exp[i-2]) begin n_bad++; $display("FAIL t2_data[%0d]: got %h expected %h", i - 2, b32.data_out, exp[i-2]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] base = 32'hA000_0000;
        int acc = 0;
        int got = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            b32.out_ready = 0; b32.in_valid = 1; b32.shift_amount = '0; b32.data_in = base + acc;
            #1;
            if (b32.out_valid) begin
                n_cmp++; if (b32.data_out !== base) begin n_bad++; $display("FAIL t3_stable: got %h expected %h", b32.data_out, base); end
            end
            if (b32.in_ready) acc++;
        end
        n_cmp++; if (acc != STALL_CAP) begin n_bad++; $display("FAIL t3_accepted: got %0d expected %0d", acc, STALL_CAP); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            b32.in_valid = 0; b32.out_ready = 1;
            #1;
            if (b32.out_valid) begin
                n_cmp++; if (b32.data_out !== base + got) begin n_bad++; $display("FAIL t3_order[%0d]: got %h expected %h", got, b32.data_out, base + got); end
                got++;
            end
        end
        n_cmp++; if (got != acc) begin n_bad++; $display("FAIL t3_count: got %0d expected %0d", got, acc); end
    endtask

    task automatic test_random();
        localparam int N = 200;
        logic [31:0] q_d [$];
        logic [4:0]  q_s [$];
        logic [31:0] orig = '0;
        logic [31:0] exp_d;
        logic [4:0]  sa = '0;
        logic [4:0]  exp_s;
        bit acc_flag = 0;
        int sent = 0, got = 0, cyc = 0;
        b32.in_valid = 0;
        while (got < N && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (acc_flag) begin b32.in_valid = 0; acc_flag = 0; end
            if (!b32.in_valid && sent < N && $urandom_range(3) != 0) begin
                orig = $urandom; sa = 5'($urandom);
                b32.data_in = rol32(orig, sa); b32.shift_amount = sa; b32.in_valid = 1;
            end
            b32.out_ready = ($urandom_range(3) != 0);
            #1;
            if (b32.in_valid && b32.in_ready) begin
                q_d.push_back(orig); q_s.push_back(sa); sent++; acc_flag = 1;
            end
            if (b32.out_valid && b32.out_ready) begin
                if (q_d.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL t4_spurious: got %h expected no beat", b32.data_out);
                end else begin
                    exp_d = q_d.pop_front(); exp_s = q_s.pop_front();
                    n_cmp++; if (b32.data_out !== exp_d) begin n_bad++; $display("FAIL t4_data[%0d]: got %h expected %h", got, b32.data_out, exp_d); end
                    n_cmp++; if (b32.sa_out !== exp_s) begin n_bad++; $display("FAIL t4_sa[%0d]: got %h expected %h", got, b32.sa_out, exp_s); end
                end
                got++;
            end
        end
        @(negedge clk);
        b32.in_valid = 0;
        n_cmp++; if (got != N) begin n_bad++; $display("FAIL t4_count: got %0d expected %0d", got, N); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        b32.out_ready = 0; b32.in_valid = 1; b32.data_in = 32'h0000_00F0; b32.shift_amount = 5'd4;
        @(negedge clk); b32.in_valid = 0;
        @(negedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b1 || b32.data_out !== 32'h0000_000F) begin n_bad++; $display("FAIL t5_pre: got %b/%h expected 1/0000000f", b32.out_valid, b32.data_out); end
        reset = 1; #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t5_async_valid: got %b expected 0", b32.out_valid); end
        n_cmp++; if (b32.data_out !== 32'h0) begin n_bad++; $display("FAIL t5_async_data: got %h expected 0", b32.data_out); end
        @(negedge clk); reset = 0; b32.out_ready = 1;
        @(negedge clk);
        b32.in_valid = 1; b32.data_in = 32'h0000_0003; b32.shift_amount = 5'd1;
        #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t5_discarded: got %b expected 0", b32.out_valid); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL t5_ready: got %b expected 1", b32.in_ready); end
        @(negedge clk); b32.in_valid = 0; #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t5_early: got %b expected 0", b32.out_valid); end
        @(negedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b1 || b32.data_out !== 32'h8000_0001) begin n_bad++; $display("FAIL t5_beat: got %b/%h expected 1/80000001", b32.out_valid, b32.data_out); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        @(negedge clk);
        b32.out_ready = 0; b32.in_valid = 1; b32.data_in = 32'h1111_1111; b32.shift_amount = '0;
        @(negedge clk); b32.data_in = 32'h2222_2222;
        @(negedge clk); b32.in_valid = 0; b32.flush = 1; #1;
        n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL t6_inflight: got %b expected 1", b32.out_valid); end
        n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL t6_flush_ready: got %b expected 0", b32.in_ready); end
        @(negedge clk); b32.flush = 0; b32.out_ready = 1; #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t6_cleared: got %b expected 0", b32.out_valid); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t6_no_emit[%0d]: got %b expected 0", c, b32.out_valid); end
        end
        @(negedge clk);
        b32.in_valid = 1; b32.data_in = 32'h3333_3333; b32.shift_amount = 5'd2;
        @(negedge clk); b32.in_valid = 0; #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL t6_early: got %b expected 0", b32.out_valid); end
        @(negedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b1 || b32.data_out !== 32'hCCCC_CCCC) begin n_bad++; $display("FAIL t6_after: got %b/%h expected 1/cccccccc", b32.out_valid, b32.data_out); end
        @(negedge clk);
    endtask

    task automatic test_narrow();
        @(negedge clk);
        b1.out_ready = 1; b1.in_valid = 1; b1.data_in = 1'b1; b1.shift_amount = 1'b1;
        #1;
        n_cmp++; if (b1.in_ready !== 1'b1) begin n_bad++; $display("FAIL n_ready: got %b expected 1", b1.in_ready); end
        @(negedge clk); b1.in_valid = 0; #1;
        n_cmp++; if (b1.out_valid !== 1'b1) begin n_bad++; $display("FAIL n_latency: got %b expected 1", b1.out_valid); end
        n_cmp++; if (b1.data_out !== 1'b1) begin n_bad++; $display("FAIL n_data: got %b expected 1", b1.data_out); end
        n_cmp++; if (b1.sa_out !== 1'b1) begin n_bad++; $display("FAIL n_sa: got %b expected 1", b1.sa_out); end
        @(negedge clk); #1;
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL n_no_dup: got %b expected 0", b1.out_valid); end
        b1.out_ready = 0; b1.in_valid = 1; b1.data_in = 1'b0; b1.shift_amount = 1'b0;
        @(negedge clk); b1.in_valid = 0; b1.flush = 1; #1;
        n_cmp++; if (b1.out_valid !== 1'b1 || b1.data_out !== 1'b0) begin n_bad++; $display("FAIL n_pre_flush: got %b/%b expected 1/0", b1.out_valid, b1.data_out); end
        n_cmp++; if (b1.in_ready !== 1'b0) begin n_bad++; $display("FAIL n_flush_ready: got %b expected 0", b1.in_ready); end
        @(negedge clk); b1.flush = 0; b1.out_ready = 1; #1;
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL n_flushed: got %b expected 0", b1.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        test_flush();
        test_narrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
